alu_serial_seq: RTL

Bit-serial sequencer that computes a WIDTH-bit ALU operation using one external 1-bit ALU slice. It runs the slice for WIDTH cycles, LSB first. It latches operands and shifts them into the slice, chains the slice carry through a register, and assembles the result. It sits between a start/done requester and a single combinational 1-bit slice instance.

---
 rtl/alu_serial_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer.
// A WIDTH-bit operation is computed LSB first through one external
// combinational 1-bit ALU slice, one bit per clock cycle. Operands are
// latched at acceptance and shifted into the slice. The slice carry is
// chained through a register, and the result is assembled from the MSB side.
module alu_serial_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             err,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_s,
    input  logic             slice_r,
    input  logic             slice_cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [2:0]       r_sel;
    logic             r_arith;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic             r_err;

    // Legal opcodes are 000 through 101
    function automatic logic op_legal(input logic [2:0] o);
        return (o != 3'b110) && (o != 3'b111);
    endfunction

    // ADD and SUB are the only ops that produce carry/overflow
    function automatic logic op_arith(input logic [2:0] o);
        return (o == OP_ADD) || (o == OP_SUB);
    endfunction

    // Sequencer FSM: operand latching, per-bit shifting, carry chaining, flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= {WIDTH{1'b0}};
            r_b_sh   <= {WIDTH{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_carry  <= 1'b0;
            r_sel    <= 3'b000;
            r_arith  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        r_cout <= 1'b0;
                        r_ovf  <= 1'b0;
                        if (op_legal(op)) begin
                            r_a_sh  <= a;
                            // Subtraction is a + ~b + 1: invert b here and
                            // preload the carry so bit 0 sees cin = 1.
                            r_b_sh  <= (op == OP_SUB) ? ~b : b;
                            r_carry <= (op == OP_SUB);
                            r_sel   <= (op == OP_SUB) ? OP_ADD : op;
                            r_arith <= op_arith(op);
                            r_cnt   <= {CNT_W{1'b0}};
                            r_err   <= 1'b0;
                            r_state <= S_RUN;
                        end else begin
                            r_result <= {WIDTH{1'b0}};
                            r_err    <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_result <= {slice_r, r_result[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= slice_cout;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        // r_carry is the carry into the MSB at this point
                        r_cout  <= r_arith & slice_cout;
                        r_ovf   <= r_arith & (r_carry ^ slice_cout);
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Slice drive: live only while RUN, quiet zeros otherwise
    always_comb begin
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_s   = 3'b000;
        if (r_state == S_RUN) begin
            slice_a   = r_a_sh[0];
            slice_b   = r_b_sh[0];
            slice_cin = r_carry;
            slice_s   = r_sel;
        end else begin
            slice_a   = 1'b0;
            slice_b   = 1'b0;
            slice_cin = 1'b0;
            slice_s   = 3'b000;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;
    assign err       = r_err;

endmodule
